edge_trigger: RTL and testbench

// - Single-bit edge detector with a sample-enable. Used by the VIA (MOS6522) for
//   CA1/CA2/CB1/CB2 interrupt edges, PB6 pulse counting, shift-register clocking
//   and timer/SR interrupt flag edges.
// - Remembers the last sampled level of IN, so an edge that occurs while En is low
//   is reported on the next enabled cycle rather than lost (e.g. during chip-select).

---
 rtl/edge_trigger.sv | 29 ++
 tb/tb_edge_trigger.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/edge_trigger.sv
// Single-bit edge detector with sample enable: compares IN against the level
// last captured on an enabled clock, so edges during disabled windows are deferred.
module edge_trigger #(
    parameter bit POSEDGE = 1'b1
) (
    input  logic clk,
    input  logic nRESET,
    input  logic IN,
    input  logic En,
    output logic EDGE
);

    logic prev;
    logic active_level;

    assign active_level = POSEDGE;

    // Reset loads the active level so a line already asserted at release is not an edge.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            prev <= POSEDGE;
        end else if (En) begin
            prev <= IN;
        end
    end

    assign EDGE = nRESET & En & (IN ^ prev) & ~(IN ^ active_level);

endmodule

// File: tb/tb_edge_trigger.sv
// Self-checking bench for edge_trigger: rising and falling instances share stimulus,
// a vector table plus hand sequences feed a scoreboard queue of expected strobes.
module tb_edge_trigger;

    logic clk;
    logic nRESET;
    logic IN;
    logic En;
    logic edge_r;
    logic edge_f;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic  rst_n;
        logic  in;
        logic  en;
        logic  exp_r;
        logic  exp_f;
        string name;
    } vec_t;

    typedef struct {
        logic  exp_r;
        logic  exp_f;
        string name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    edge_trigger #(.POSEDGE(1'b1)) dut_rise (
        .clk    (clk),
        .nRESET (nRESET),
        .IN     (IN),
        .En     (En),
        .EDGE   (edge_r)
    );

    edge_trigger #(.POSEDGE(1'b0)) dut_fall (
        .clk    (clk),
        .nRESET (nRESET),
        .IN     (IN),
        .En     (En),
        .EDGE   (edge_f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check({e.name, "_rise"}, edge_r, e.exp_r);
            check({e.name, "_fall"}, edge_f, e.exp_f);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 2 time units
    // before the next rising edge, once the combinational strobe has settled.
    task automatic drive(input logic rst_n, input logic in, input logic en,
                         input logic exp_r, input logic exp_f, input string name);
        @(negedge clk);
        nRESET = rst_n;
        IN     = in;
        En     = en;
        sb.push_back('{exp_r, exp_f, name});
        #3;
        compare();
    endtask

    initial begin
        int rise_count;
        nRESET = 1'b0;
        IN     = 1'b1;
        En     = 1'b1;

        //               rst  in   en   r    f
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "reset_held"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "release_in_high"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "fall_1to0"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "rise_0to1"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "rise_clears"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "fall_again"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "fall_clears"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "rise_again"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "fall_while_dis0"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "fall_while_dis1"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "fall_deferred"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rise_while_dis0"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rise_while_dis1"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rise_while_dis2"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rise_while_dis3"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rise_while_dis4"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "rise_deferred"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "deferred_clears"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "fall_pre_pulse"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "pulse_high_dis"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "pulse_low_dis"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "short_pulse_lost"});

        foreach (vecs[i])
            drive(vecs[i].rst_n, vecs[i].in, vecs[i].en,
                  vecs[i].exp_r, vecs[i].exp_f, vecs[i].name);

        // Asynchronous reset arriving mid-cycle while a rising strobe is up.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "rst_mid_pre");
        #1 nRESET = 1'b0;
        #1;
        sb.push_back('{1'b0, 1'b0, "rst_mid_async"});
        compare();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "rst_release_in1");

        // clk_en pattern: En high on even cycles, IN square wave of period 8.
        rise_count = 0;
        for (int c = 0; c < 40; c++) begin
            logic in_c;
            logic en_c;
            in_c = ((c % 8) >= 4);
            en_c = ((c % 2) == 0);
            drive(1'b1, in_c, en_c, (c % 8) == 4, (c % 8) == 0, $sformatf("clken_c%0d", c));
            if (edge_r === 1'b1) rise_count++;
        end
        check("clken_rise_total", (rise_count == 5), 1'b1);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
